mem_access_unit: RTL

- Load/store stage of the 5-stage MIPS pipeline, sitting between EX/MEM and MEM/WB.
- Runs every memory op as a multi-cycle req/ack bus transaction and stalls the pipeline until the transaction completes.
- Supports byte, halfword and word accesses with sign/zero extension, LL/SC with an internal LLbit, address-error detection and a bus-timeout error.

---
 rtl/mem_access_unit.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// MIPS MEM-stage load/store unit. Each memory op becomes a req/ack bus transaction,
// with sub-word lanes, LL/SC, address errors and a bus timeout.
module mem_access_unit #(
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 255,
  parameter bit BIG_ENDIAN  = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  input  logic [3:0]        op_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  input  logic              flush_i,
  output logic              stall_o,
  output logic              done_o,
  output logic [31:0]       rdata_o,
  output logic [4:0]        exc_o,
  output logic [ADDR_W-1:0] badvaddr_o,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [3:0]        bus_sel_o,
  output logic [31:0]       bus_wdata_o,
  input  logic              bus_ack_i,
  input  logic [31:0]       bus_rdata_i,
  output logic              llbit_o
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DRAIN, S_DONE} state_e;

  typedef enum logic [3:0] {
    OP_NONE = 4'd0, OP_LB = 4'd1, OP_LBU = 4'd2, OP_LH = 4'd3, OP_LHU = 4'd4,
    OP_LW   = 4'd5, OP_SB = 4'd6, OP_SH  = 4'd7, OP_SW = 4'd8, OP_LL  = 4'd9,
    OP_SC   = 4'd10
  } op_e;

  state_e            r_state;
  op_e               r_op;
  logic [ADDR_W-1:0] r_addr;
  logic [15:0]       r_cnt;
  logic              r_llbit;

  logic        w_op_valid;
  logic        w_is_store;
  logic        w_is_half;
  logic        w_is_word;
  logic        w_misalign;
  logic        w_accept;
  logic        w_timeout;
  logic [1:0]  w_lane;
  logic        w_half;
  logic [3:0]  w_sel;
  logic [31:0] w_wdata;
  logic [1:0]  w_rlane;
  logic [7:0]  w_rbyte;
  logic [15:0] w_rhword;
  logic [31:0] w_load_data;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_op_valid = 1'b1;
    w_is_store = 1'b0;
    w_is_half  = 1'b0;
    w_is_word  = 1'b0;
    case (op_i)
      OP_LB, OP_LBU: ;
      OP_LH, OP_LHU: w_is_half = 1'b1;
      OP_LW, OP_LL:  w_is_word = 1'b1;
      OP_SB:         w_is_store = 1'b1;
      OP_SH: begin
        w_is_store = 1'b1;
        w_is_half  = 1'b1;
      end
      OP_SW, OP_SC: begin
        w_is_store = 1'b1;
        w_is_word  = 1'b1;
      end
      default:       w_op_valid = 1'b0;
    endcase
  end

  assign w_misalign = (w_is_half & addr_i[0]) | (w_is_word & (|addr_i[1:0]));
  assign w_accept   = (r_state == S_IDLE) & valid_i & w_op_valid & ~flush_i;
  assign w_timeout  = (r_cnt == 16'(TIMEOUT_CYC - 1));

  // Byte/halfword lane selection flips with endianness.
  assign w_lane = addr_i[1:0] ^ {2{BIG_ENDIAN}};
  assign w_half = addr_i[1] ^ BIG_ENDIAN;

  always_comb begin
    w_sel   = 4'b1111;
    w_wdata = wdata_i;
    if (op_i == OP_SB) begin
      w_sel   = 4'b0001 << w_lane;
      w_wdata = {4{wdata_i[7:0]}};
    end else if (op_i == OP_SH) begin
      w_sel   = w_half ? 4'b1100 : 4'b0011;
      w_wdata = {2{wdata_i[15:0]}};
    end
  end

  assign w_rlane  = r_addr[1:0] ^ {2{BIG_ENDIAN}};
  assign w_rhword = (r_addr[1] ^ BIG_ENDIAN) ? bus_rdata_i[31:16] : bus_rdata_i[15:0];

  always_comb begin
    w_rbyte = bus_rdata_i[7:0];
    case (w_rlane)
      2'd1:    w_rbyte = bus_rdata_i[15:8];
      2'd2:    w_rbyte = bus_rdata_i[23:16];
      2'd3:    w_rbyte = bus_rdata_i[31:24];
      default: w_rbyte = bus_rdata_i[7:0];
    endcase
  end

  always_comb begin
    w_load_data = bus_rdata_i;
    case (r_op)
      OP_LB:               w_load_data = {{24{w_rbyte[7]}}, w_rbyte};
      OP_LBU:              w_load_data = {24'd0, w_rbyte};
      OP_LH:               w_load_data = {{16{w_rhword[15]}}, w_rhword};
      OP_LHU:              w_load_data = {16'd0, w_rhword};
      OP_SC:               w_load_data = 32'd1;
      OP_SB, OP_SH, OP_SW: w_load_data = 32'd0;
      default:             w_load_data = bus_rdata_i;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_op        <= OP_NONE;
      r_addr      <= '0;
      r_cnt       <= '0;
      rdata_o     <= '0;
      exc_o       <= '0;
      badvaddr_o  <= '0;
      bus_req_o   <= 1'b0;
      bus_we_o    <= 1'b0;
      bus_addr_o  <= '0;
      bus_sel_o   <= '0;
      bus_wdata_o <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op   <= op_e'(op_i);
            r_addr <= addr_i;
            r_cnt  <= '0;
            if (w_misalign) begin
              exc_o      <= w_is_store ? 5'd5 : 5'd4;
              badvaddr_o <= addr_i;
              rdata_o    <= '0;
              r_state    <= S_DONE;
            end else if (op_i == OP_SC && !r_llbit) begin
              exc_o   <= '0;
              rdata_o <= '0;
              r_state <= S_DONE;
            end else begin
              bus_req_o   <= 1'b1;
              bus_we_o    <= w_is_store;
              bus_addr_o  <= {addr_i[ADDR_W-1:2], 2'b00};
              bus_sel_o   <= w_sel;
              bus_wdata_o <= w_wdata;
              r_state     <= S_BUSY;
            end
          end
        end
        S_BUSY, S_DRAIN: begin
          if (bus_ack_i || w_timeout) begin
            bus_req_o <= 1'b0;
            // A flushed transaction finishes on the bus but its result is dropped.
            if (r_state == S_BUSY && !flush_i) begin
              r_state <= S_DONE;
              if (bus_ack_i) begin
                rdata_o <= w_load_data;
                exc_o   <= '0;
              end else begin
                rdata_o    <= '0;
                exc_o      <= 5'd7;
                badvaddr_o <= r_addr;
              end
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_cnt <= r_cnt + 16'd1;
            if (flush_i) r_state <= S_DRAIN;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      r_llbit <= 1'b0;
    end else if (r_state == S_DONE && r_op == OP_SC) begin
      r_llbit <= 1'b0;
    end else if (r_state == S_DONE && r_op == OP_LL && exc_o == 5'd0) begin
      r_llbit <= 1'b1;
    end
  end

  assign llbit_o = r_llbit;
  assign done_o  = (r_state == S_DONE) & ~flush_i;
  assign stall_o = valid_i & w_op_valid & (r_state != S_DONE);

endmodule
